// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the five-stage core.
// Mult/div sequencer state encoding and default latencies.
package pipe_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam int MD_MULT_CYCLES = 4;
    localparam int MD_DIV_CYCLES  = 32;
    localparam int MD_CNT_W       = $clog2(MD_DIV_CYCLES);

endpackage

// File: rtl/md_seq.sv
// Mult/div sequencer: start pulse, latency down-counter, HI/LO write strobe.
// md_start to md_done spans exactly (latency - 1) cycles.
module md_seq
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    input  logic is_mult,
    output logic md_start,
    output logic md_done,
    output logic md_busy
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ld;

    assign ld = is_mult ? CNT_W'(MULT_CYCLES - 2)
                        : CNT_W'(DIV_CYCLES - 2);

    assign md_start = (state == MD_IDLE) && start_req;
    assign md_done  = (state == MD_DONE);
    assign md_busy  = (state != MD_IDLE);

    // A zero load value means the op needs no BUSY cycles at all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (start_req) begin
                        cnt   <= ld;
                        state <= (ld == '0) ? MD_DONE : MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= MD_DONE;
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use, HI/LO structural
// stalls, MEM redirect flush, syscall halt and stall-cycle counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_md_op,
    input  logic        id_lhr_ren,
    input  logic        ex_rf_wen,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_is_load,
    input  logic        ex_md_op,
    input  logic        ex_md_is_mult,
    input  logic        mem_redirect,
    input  logic        wb_syscall,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_clr,
    output logic        id_ex_clr,
    output logic        ex_mem_clr,
    output logic        md_start,
    output logic        md_done,
    output logic        md_busy,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    logic load_use;
    logic md_hazard;
    logic start_req;

    // A mult/div op in EX alongside a redirect is younger and is squashed.
    assign start_req = ex_md_op && !mem_redirect && !halted;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_seq (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req),
        .is_mult   (ex_md_is_mult),
        .md_start  (md_start),
        .md_done   (md_done),
        .md_busy   (md_busy)
    );

    assign load_use = ex_is_load && ex_rf_wen && (ex_rf_waddr != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rf_waddr)) ||
                       (id_uses_rt && (id_rt == ex_rf_waddr)));

    assign md_hazard = (md_busy || md_start) && (id_md_op || id_lhr_ren);

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_clr   = 1'b0;
        id_ex_clr   = 1'b0;
        ex_mem_clr  = 1'b0;
        if (halted) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_clr   = 1'b1;
            ex_mem_clr  = 1'b1;
        end else if (mem_redirect) begin
            if_id_clr   = 1'b1;
            id_ex_clr   = 1'b1;
            ex_mem_clr  = 1'b1;
        end else if (load_use || md_hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (wb_syscall)
                halted <= 1'b1;
            if (pc_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-value queue.
// Bit order: pc,ifid_stall,ifid_clr,idex_clr,exmem_clr,start,done,busy,halt.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt, id_md_op, id_lhr_ren;
    logic        ex_rf_wen;
    logic [4:0]  ex_rf_waddr;
    logic        ex_is_load, ex_md_op, ex_md_is_mult;
    logic        mem_redirect, wb_syscall;
    logic        pc_stall, if_id_stall, if_id_clr, id_ex_clr, ex_mem_clr;
    logic        md_start, md_done, md_busy, halted;
    logic [31:0] stall_cycles;

    typedef struct {
        string       tag;
        logic [8:0]  bits;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sc = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_md_op      (id_md_op),
        .id_lhr_ren    (id_lhr_ren),
        .ex_rf_wen     (ex_rf_wen),
        .ex_rf_waddr   (ex_rf_waddr),
        .ex_is_load    (ex_is_load),
        .ex_md_op      (ex_md_op),
        .ex_md_is_mult (ex_md_is_mult),
        .mem_redirect  (mem_redirect),
        .wb_syscall    (wb_syscall),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_clr     (if_id_clr),
        .id_ex_clr     (id_ex_clr),
        .ex_mem_clr    (ex_mem_clr),
        .md_start      (md_start),
        .md_done       (md_done),
        .md_busy       (md_busy),
        .halted        (halted),
        .stall_cycles  (stall_cycles)
    );

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_md_op = 0; id_lhr_ren = 0; ex_rf_wen = 0; ex_rf_waddr = 0;
        ex_is_load = 0; ex_md_op = 0; ex_md_is_mult = 0;
        mem_redirect = 0; wb_syscall = 0;
    endtask

    // Push expectation, compare at negedge, then advance to the next cycle.
    task automatic cyc(input string tag, input logic [8:0] bits);
        exp_t e;
        logic [8:0] obs;
        e.tag = tag; e.bits = bits; e.cnt = exp_sc;
        sb.push_back(e);
        if (bits[8]) exp_sc = exp_sc + 1;
        @(negedge clk);
        e = sb.pop_front();
        obs = {pc_stall, if_id_stall, if_id_clr, id_ex_clr, ex_mem_clr,
               md_start, md_done, md_busy, halted};
        checks++;
        assert (obs === e.bits) else begin
            errors++;
            $error("FAIL %s ctrl got %b exp %b", e.tag, obs, e.bits);
        end
        checks++;
        assert (stall_cycles === e.cnt) else begin
            errors++;
            $error("FAIL %s stall_cycles got %0d exp %0d",
                   e.tag, stall_cycles, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_rs5();
        ex_is_load = 1; ex_rf_wen = 1; ex_rf_waddr = 5;
        id_rs = 5; id_uses_rs = 1;
    endtask

    initial begin
        idle();
        rst = 0;
        @(posedge clk); #1;
        cyc("reset", 9'b000000000);
        rst = 1;
        cyc("post_reset", 9'b000000000);

        load_use_rs5();
        cyc("lu_rs", 9'b110100000);
        idle();
        cyc("lu_after", 9'b000000000);
        load_use_rs5(); ex_rf_waddr = 0; id_rs = 0;
        cyc("lu_r0", 9'b000000000);
        idle();
        ex_is_load = 1; ex_rf_wen = 1; ex_rf_waddr = 7;
        id_rt = 7; id_uses_rt = 1;
        cyc("lu_rt", 9'b110100000);
        ex_rf_wen = 0;
        cyc("lu_nowen", 9'b000000000);
        idle();

        ex_md_op = 1; ex_md_is_mult = 1; id_lhr_ren = 1;
        cyc("mult_c0", 9'b110101000);
        ex_md_op = 0;
        cyc("mult_c1", 9'b110100010);
        cyc("mult_c2", 9'b110100010);
        cyc("mult_c3", 9'b110100110);
        cyc("mfhi_rel", 9'b000000000);
        idle();

        ex_md_op = 1;
        cyc("div_c0", 9'b000001000);
        ex_md_op = 0;
        for (int i = 1; i <= 30; i++) cyc("div_busy", 9'b000000010);
        cyc("div_c31", 9'b000000110);
        cyc("div_idle", 9'b000000000);

        load_use_rs5(); mem_redirect = 1;
        cyc("redir_lu", 9'b001110000);
        ex_md_op = 1; ex_md_is_mult = 1;
        cyc("redir_md", 9'b001110000);
        idle();
        cyc("redir_nostart", 9'b000000000);

        ex_md_op = 1; ex_md_is_mult = 1;
        cyc("rb_c0", 9'b000001000);
        idle(); mem_redirect = 1;
        cyc("rb_c1", 9'b001110010);
        idle();
        cyc("rb_c2", 9'b000000010);
        cyc("rb_c3", 9'b000000110);
        cyc("rb_c4", 9'b000000000);

        ex_md_op = 1; ex_md_is_mult = 1; id_md_op = 1;
        cyc("b2b_c0", 9'b110101000);
        ex_md_op = 0;
        cyc("b2b_c1", 9'b110100010);
        cyc("b2b_c2", 9'b110100010);
        cyc("b2b_c3", 9'b110100110);
        id_md_op = 0; ex_md_op = 1;
        cyc("b2b_c4", 9'b000001000);
        ex_md_op = 0;
        cyc("b2b_c5", 9'b000000010);
        cyc("b2b_c6", 9'b000000010);
        cyc("b2b_c7", 9'b000000110);
        idle();

        ex_md_op = 1; ex_md_is_mult = 0;
        cyc("rdiv_c0", 9'b000001000);
        ex_md_op = 0;
        for (int i = 1; i < 10; i++) cyc("rdiv_busy", 9'b000000010);
        rst = 0; exp_sc = 0;
        cyc("rdiv_rst", 9'b000000000);
        rst = 1;
        for (int i = 0; i < 30; i++) cyc("rdiv_nodone", 9'b000000000);

        ex_md_op = 1; ex_md_is_mult = 1;
        cyc("halt_c0", 9'b000001000);
        idle(); wb_syscall = 1;
        cyc("halt_c1", 9'b000000010);
        wb_syscall = 0;
        cyc("halt_c2", 9'b110110011);
        cyc("halt_c3", 9'b110110111);
        cyc("halt_c4", 9'b110110001);
        mem_redirect = 1;
        cyc("halt_redir", 9'b110110001);
        mem_redirect = 0; ex_md_op = 1;
        cyc("halt_md", 9'b110110001);
        idle();
        cyc("halt_sticky", 9'b110110001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It decides each cycle whether the PC and IF/ID register hold, and which pipeline registers (IF/ID, ID/EX, EX/MEM) are cleared. It detects load-use hazards and flushes on branch/jump redirects resolved in MEM. It also sequences the multi-cycle mult/div unit, stalling HI/LO consumers until the result is written, and halts the pipeline on syscall.

## Interface
- `MULT_CYCLES`, default 4: mult latency, start to HI/LO write, in cycles (≥2).
- `DIV_CYCLES`, default 32: div latency in cycles (≥2, ≥`MULT_CYCLES`).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `id_rs`, `id_rt` input 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` input 1 each: the ID instruction reads that source.
- `id_md_op` input 1: ID instruction is mult/multu/div/divu.
- `id_lhr_ren` input 1: ID instruction reads HI/LO (mfhi/mflo).
- `ex_rf_wen` input 1: EX-stage register-file write enable.
- `ex_rf_waddr` input 5: EX-stage register-file write address.
- `ex_is_load` input 1: EX instruction is a load.
- `ex_md_op` input 1: EX instruction is a mult/div op.
- `ex_md_is_mult` input 1: EX mult/div op is a multiply (1) or divide (0).
- `mem_redirect` input 1: taken branch, jump or jump-register resolved in MEM.
- `wb_syscall` input 1: syscall retiring in WB.
- `pc_stall` output 1: PC holds its value.
- `if_id_stall` output 1: IF/ID register holds its value.
- `if_id_clr`, `id_ex_clr`, `ex_mem_clr` output 1 each: synchronous clear of that register next edge.
- `md_start` output 1: one-cycle start pulse to the mult/div datapath.
- `md_done` output 1: one-cycle HI/LO write strobe.
- `md_busy` output 1: mult/div operation in flight (state ≠ MD_IDLE).
- `halted` output 1: sticky halt after syscall.
- `stall_cycles` output 32: count of cycles with `pc_stall`=1, saturating at 0xFFFF_FFFF.

## Operation
- Load-use hazard: `ex_is_load & ex_rf_wen & ex_rf_waddr≠0 & ((id_uses_rs & id_rs==ex_rf_waddr) | (id_uses_rt & id_rt==ex_rf_waddr))`. Response: `pc_stall`, `if_id_stall`, `id_ex_clr` for that cycle (one bubble).
- MD FSM states: MD_IDLE, MD_BUSY, MD_DONE.
  - MD_IDLE: if `ex_md_op & ~mem_redirect & ~halted`, assert `md_start`, load the down-counter with `MULT_CYCLES-2` (mult) or `DIV_CYCLES-2` (div), and go to MD_BUSY.
  - MD_BUSY: decrement the counter. At 0, go to MD_DONE.
  - MD_DONE: assert `md_done`, go to MD_IDLE.
- Structural hazard: in MD_BUSY or MD_DONE, or when `md_start`=1, an ID instruction with `id_md_op | id_lhr_ren` causes `pc_stall`, `if_id_stall`, `id_ex_clr`.
- Redirect: `mem_redirect` gives `if_id_clr`, `id_ex_clr`, `ex_mem_clr`, and forces `pc_stall`=`if_id_stall`=0 so the PC loads the target.
  - Redirect has priority over load-use and structural stalls.
  - An in-flight mult/div op is older than the branch and runs to completion.
  - An EX mult/div op in the same cycle as the redirect is younger and never starts.
- Halt: `wb_syscall` sets `halted` on the next edge; `halted` clears only on reset.
  - While halted: `pc_stall`=`if_id_stall`=`id_ex_clr`=`ex_mem_clr`=1 and `if_id_clr`=0.
  - A running mult/div op still finishes, so `md_done` still pulses.
  - Halt overrides redirect.
- `stall_cycles` increments on every edge where `pc_stall`=1, and holds at all-ones.

## Timing
- Reset (`rst`=0): MD FSM goes to MD_IDLE, the counter and `stall_cycles` go to 0, and `halted` goes to 0.
  - Consequently all outputs are 0 during and immediately after reset.
  - Reset mid-operation abandons the mult/div op; no `md_done` is issued.
- Stall and clear outputs are combinational from the current inputs and registered state; there is zero-cycle latency to the pipeline registers.
- `md_start` to `md_done` is exactly `MULT_CYCLES`-1 cycles for mult and `DIV_CYCLES`-1 cycles for div, so HI/LO are written on the `MULT_CYCLES`-th (or `DIV_CYCLES`-th) edge after start.
- An mfhi held in ID is released in the cycle after MD_DONE.
- Back-to-back mult/div ops: the second is held in ID until MD_IDLE, then issues. A new `md_start` is possible in the cycle after MD_DONE.
- Load-use and structural stalls in the same cycle produce a single bubble per cycle, with no double counting.

## Structure
- Shared package `pipe_pkg` holds:
  - the `md_state_t` enum (MD_IDLE, MD_BUSY, MD_DONE);
  - default latency constants `MD_MULT_CYCLES`=4 and `MD_DIV_CYCLES`=32;
  - counter width `MD_CNT_W`=$clog2(`DIV_CYCLES`).
- One sub-module, `md_seq`, contains the MD FSM and down-counter. It outputs `md_start`, `md_done`, `md_busy`.
- The top level holds the hazard equations, priority logic, halt flag and stall counter.

## Test plan
- Load-use: `ex_is_load`=1, `ex_rf_waddr`=5, `id_rs`=5, `id_uses_rs`=1 -> one cycle with `pc_stall`=`if_id_stall`=`id_ex_clr`=1 and `stall_cycles`=1. With `ex_rf_waddr`=0 -> no stall.
- Mult then mfhi: `ex_md_op`=1, `ex_md_is_mult`=1 at cycle 0 with mfhi in ID -> `md_start` at cycle 0, `md_done` at cycle 3, stall over cycles 0-3, release at cycle 4. A div op gives `md_done` at cycle 31.
- Redirect during load-use: `mem_redirect`=1 with a load-use condition -> `pc_stall`=0 and all three clears asserted. With `ex_md_op`=1 in the same cycle -> no `md_start`.
- Redirect during MD_BUSY -> the op completes with `md_done` on schedule, and the flush applies.
- Syscall: `wb_syscall` pulse -> `halted`=1 from the next cycle, stalls sticky, and a redirect afterwards is ignored.
- Reset mid-div: `rst`=0 at cycle 10 of a div -> `md_busy`=0 immediately, no `md_done`, and `stall_cycles`=0.
